datapath_ctrl: RTL

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_pkg.sv | 38 +++
 rtl/datapath_ctrl_glut_loader.sv | 63 ++++++
 rtl/datapath_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the pixel datapath controller and its
// gamma-table loader.
package datapath_ctrl_pkg;

    // Number of gamma LUT entries written by one table load.
    localparam int GLUT_DEPTH = 256;

    // LUT address / data widths and pixel component width.
    localparam int PADDR_W = $clog2(GLUT_DEPTH);
    localparam int PDATA_W = 8;
    localparam int COMP_W  = 8;

    typedef logic [PADDR_W-1:0] PADDR;
    typedef logic [PDATA_W-1:0] PDATA;

    // One RGB pixel as it travels from the source to the datapath.
    typedef struct packed {
        logic [COMP_W-1:0] r;
        logic [COMP_W-1:0] g;
        logic [COMP_W-1:0] b;
    } color_t;

    // Per-frame stage enables captured at start.
    typedef struct packed {
        logic g_en;
        logic c_en;
        logic b_en;
    } stage_cfg_t;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/datapath_ctrl_glut_loader.sv
// Gamma LUT loader: walks the source table addresses once, then replays
// each address one cycle later together with the returned data as an
// active-low write into the LUT.
module datapath_ctrl_glut_loader
    import datapath_ctrl_pkg::*;
#(
    parameter int DEPTH = GLUT_DEPTH
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    output PADDR o_rd_addr,
    input  PDATA i_rd_data,
    output logic o_we_n,
    output PADDR o_from,
    output PDATA o_to,
    output logic o_done
);

    localparam PADDR LAST_ADDR = PADDR'(DEPTH - 1);

    logic r_rd_active;
    PADDR r_addr;
    logic r_wr_active;
    PADDR r_from;

    // Address issue counter; the write stage trails it by exactly one cycle
    // so that the synchronous source memory has its data ready.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_active <= 1'b0;
            r_addr      <= '0;
            r_wr_active <= 1'b0;
            r_from      <= '0;
        end else begin
            r_wr_active <= r_rd_active;
            if (r_rd_active) begin
                r_from <= r_addr;
            end
            if (i_start) begin
                r_rd_active <= 1'b1;
                r_addr      <= '0;
            end else if (r_rd_active) begin
                if (r_addr == LAST_ADDR) begin
                    r_rd_active <= 1'b0;
                    r_addr      <= '0;
                end else begin
                    r_addr <= r_addr + PADDR'(1);
                end
            end
        end
    end

    assign o_rd_addr = r_addr;
    assign o_we_n    = ~r_wr_active;
    assign o_from    = r_from;
    // Read data is only meaningful while a write is in flight; keep the bus
    // quiet otherwise.
    assign o_to      = r_wr_active ? i_rd_data : '0;
    // Last write cycle: no more addresses pending, final write on the bus.
    assign o_done    = r_wr_active & ~r_rd_active;

endmodule

// File: rtl/datapath_ctrl.sv
// Frame sequencer for the pixel datapath: optionally loads the gamma LUT,
// then streams a fixed number of source pixels into the datapath through a
// single registered output stage, and pulses frame_done at the end.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int GLUT_DEPTH = datapath_ctrl_pkg::GLUT_DEPTH,
    parameter int SIZE_W     = 20
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start,
    input  logic              load_glut,
    input  logic              cfg_g_en,
    input  logic              cfg_c_en,
    input  logic              cfg_b_en,
    input  logic [SIZE_W-1:0] frame_size,
    output PADDR              glut_rd_addr,
    input  PDATA              glut_rd_data,
    input  color_t            src_color,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              glut_write_en_n,
    output PADDR              glut_from,
    output PDATA              glut_to,
    output logic              g_en,
    output logic              c_en,
    output logic              b_en,
    output color_t            color_in,
    output logic              color_in_valid,
    input  logic              datapath_ready,
    output logic              busy,
    output logic              frame_done
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    logic [SIZE_W-1:0] r_remain;
    stage_cfg_t        r_cfg;
    color_t            r_color_in;
    logic              r_color_in_valid;

    logic              w_start_accept;
    logic              w_loader_start;
    logic              w_load_done;
    logic              w_src_ready;
    logic              w_handshake;
    logic              w_stage_on;
    logic              w_remain_zero;

    assign w_start_accept = (r_state == IDLE) && start;
    assign w_remain_zero  = (r_remain == '0);
    assign w_handshake    = src_valid && w_src_ready;

    datapath_ctrl_glut_loader #(
        .DEPTH (GLUT_DEPTH)
    ) u_glut_loader (
        .clk       (clk),
        .i_rst_n   (resetN),
        .i_start   (w_loader_start),
        .o_rd_addr (glut_rd_addr),
        .i_rd_data (glut_rd_data),
        .o_we_n    (glut_write_en_n),
        .o_from    (glut_from),
        .o_to      (glut_to),
        .o_done    (w_load_done)
    );

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_next   = r_state;
        w_loader_start = 1'b0;
        w_src_ready    = 1'b0;
        w_stage_on     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = load_glut ? LOAD : STREAM;
                    w_loader_start = load_glut;
                end
            end
            LOAD: begin
                if (w_load_done) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                w_stage_on  = 1'b1;
                w_src_ready = datapath_ready && !w_remain_zero;
                // Leave only once the final pixel has been taken downstream.
                if (w_remain_zero && (!r_color_in_valid || datapath_ready)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_stage_on   = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Frame configuration and remaining-pixel count, captured at start.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_remain <= '0;
            r_cfg    <= '0;
        end else if (w_start_accept) begin
            r_remain <= frame_size;
            r_cfg    <= '{g_en: cfg_g_en, c_en: cfg_c_en, b_en: cfg_b_en};
        end else if (w_handshake) begin
            // A handshake implies a non-zero count, so this cannot wrap.
            r_remain <= r_remain - SIZE_W'(1);
        end
    end

    // Output pixel stage; frozen whenever the datapath is not ready.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_color_in       <= '0;
            r_color_in_valid <= 1'b0;
        end else if (datapath_ready) begin
            r_color_in_valid <= w_handshake;
            if (w_handshake) begin
                r_color_in <= src_color;
            end
        end
    end

    assign src_ready      = w_src_ready;
    assign g_en           = w_stage_on & r_cfg.g_en;
    assign c_en           = w_stage_on & r_cfg.c_en;
    assign b_en           = w_stage_on & r_cfg.b_en;
    assign color_in       = r_color_in;
    assign color_in_valid = r_color_in_valid;
    assign busy           = (r_state != IDLE);
    assign frame_done     = (r_state == DONE);

endmodule
